// File: rtl/psum_ofifo.sv
// Row-aligned output FIFO for the mac_tile array: per-column psum capture, one full row popped at a time.
// Optional build macro PSUM_OFIFO_RELU_EN clamps negative readout slices to zero.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*psum_bw-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [col*psum_bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_ready,
    output logic                     o_ovf
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    function automatic logic [psum_bw-1:0] readout_map(input logic signed [psum_bw-1:0] v);
`ifdef PSUM_OFIFO_RELU_EN
        if (v < 0) begin
            return '0;
        end
        return v;
`else
        return v;
`endif
    endfunction

    logic [col-1:0] col_nz;
    logic [col-1:0] col_full;
    logic [col-1:0] col_ovf;
    logic           pop;

    assign o_valid = &col_nz;
    assign o_full  = |col_full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        logic [psum_bw-1:0] mem [depth];
        logic [AW-1:0]      wptr;
        logic [AW-1:0]      rptr;
        logic [CW-1:0]      count;
        logic               push;

        assign col_full[i] = (count == FULL_CNT);
        assign col_nz[i]   = (count != '0);
        // A pop in the same cycle frees the head slot, so a full column may still accept.
        assign push        = wr[i] & (~col_full[i] | pop);
        assign col_ovf[i]  = wr[i] & col_full[i] & ~pop;

        always_ff @(posedge clk) begin
            if (reset) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + AW'(1);
                end
                if (pop) begin
                    rptr <= rptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wptr] <= in[i*psum_bw +: psum_bw];
            end
        end

        assign out[i*psum_bw +: psum_bw] = o_valid ? readout_map(mem[rptr]) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_ovf <= 1'b0;
        end else if (|col_ovf) begin
            o_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomized self-checking bench for psum_ofifo against a per-column queue model.
module tb_psum_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [COL*BW-1:0]   in_bus = '0;
    logic [COL-1:0]      wr = '0;
    logic                rd = 1'b0;
    logic [COL*BW-1:0]   out;
    logic                o_valid;
    logic                o_full;
    logic                o_ready;
    logic                o_ovf;

    int total = 0;
    int bad   = 0;

    typedef logic [BW-1:0] psum_q_t [$];
    psum_q_t mq [COL];
    bit      m_ovf = 1'b0;

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in(in_bus), .wr(wr), .rd(rd),
        .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    function automatic bit m_valid();
        for (int i = 0; i < COL; i++) if (mq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < COL; i++) if (mq[i].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [BW-1:0] m_map(input logic [BW-1:0] v);
`ifdef PSUM_OFIFO_RELU_EN
        return v[BW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [COL*BW-1:0] m_out();
        logic [COL*BW-1:0] r;
        r = '0;
        if (m_valid()) for (int i = 0; i < COL; i++) r[i*BW +: BW] = m_map(mq[i][0]);
        return r;
    endfunction

    function automatic logic [COL*BW-1:0] rand_row();
        logic [COL*BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // Apply one cycle of stimulus, advance the model over the same edge, settle.
    task automatic step(input logic [COL-1:0] w, input logic r, input logic [COL*BW-1:0] d,
                        input logic rst = 1'b0);
        bit p;
        bit f;
        wr = w; rd = r; in_bus = d; reset = rst;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < COL; i++) mq[i].delete();
            m_ovf = 1'b0;
        end else begin
            p = r && m_valid();
            for (int i = 0; i < COL; i++) begin
                f = (mq[i].size() == DEPTH);
                if (p) void'(mq[i].pop_front());
                if (w[i] && (!f || p)) mq[i].push_back(d[i*BW +: BW]);
                if (w[i] && f && !p) m_ovf = 1'b1;
            end
        end
        #1;
        wr = '0; rd = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        step('0, 1'b0, '0, 1'b1);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        total++; if (o_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", o_full); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", o_ovf); end
        total++; if (out !== '0) begin bad++; $display("FAIL reset_out: got %h want 0", out); end
    endtask

    task automatic test_single_row();
        logic [COL*BW-1:0] d;
        for (int i = 0; i < COL; i++) d[i*BW +: BW] = BW'(i + 1);
        step('1, 1'b0, d);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL row_valid: got %b want 1", o_valid); end
        total++; if (out !== d) begin bad++; $display("FAIL row_out: got %h want %h", out, d); end
        step('0, 1'b1, '0);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL row_pop_valid: got %b want 0", o_valid); end
        total++; if (out !== '0) begin bad++; $display("FAIL row_pop_out: got %h want 0", out); end
    endtask

    task automatic test_skew();
        logic [COL-1:0] w;
        step('0, 1'b0, '0, 1'b1);
        for (int i = 0; i < COL; i++) begin
            w = '0; w[i] = 1'b1;
            step(w, 1'b0, rand_row());
            total++;
            if (o_valid !== ((i == COL - 1) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL skew_valid[%0d]: got %b want %b", i, o_valid, i == COL - 1);
            end
        end
        total++; if (out !== m_out()) begin bad++; $display("FAIL skew_out: got %h want %h", out, m_out()); end
        step('0, 1'b1, '0);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL skew_pop: got %b want 0", o_valid); end
    endtask

    task automatic test_full_ovf();
        logic [BW-1:0] first;
        logic [COL*BW-1:0] d;
        step('0, 1'b0, '0, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            d = rand_row();
            if (k == 0) first = d[BW-1:0];
            step(8'h01, 1'b0, d);
        end
        total++; if (o_full !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", o_full); end
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", o_ready); end
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL full_ovf_early: got %b want 0", o_ovf); end
        step(8'h01, 1'b0, rand_row());
        total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", o_ovf); end
        step(8'hFE, 1'b0, rand_row());
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", o_valid); end
        total++; if (out[BW-1:0] !== m_map(first)) begin bad++; $display("FAIL ovf_head: got %h want %h", out[BW-1:0], m_map(first)); end
        total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", o_ovf); end
    endtask

    task automatic test_full_pop_write();
        step('0, 1'b0, '0, 1'b1);
        for (int k = 0; k < DEPTH; k++) step(8'h01, 1'b0, rand_row());
        step(8'hFE, 1'b0, rand_row());
        step(8'h01, 1'b1, rand_row());
        total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL fpw_ovf: got %b want 0", o_ovf); end
        total++; if (o_full !== 1'b1) begin bad++; $display("FAIL fpw_full: got %b want 1", o_full); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fpw_valid: got %b want 0", o_valid); end
        step(8'hFE, 1'b0, rand_row());
        total++; if (out !== m_out()) begin bad++; $display("FAIL fpw_out: got %h want %h", out, m_out()); end
    endtask

    task automatic test_rd_empty();
        logic [COL*BW-1:0] d1, d2, exp;
        step('0, 1'b0, '0, 1'b1);
        d1 = rand_row(); d2 = rand_row();
        step(8'h7F, 1'b0, d1);
        step('0, 1'b1, '0);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rde_valid: got %b want 0", o_valid); end
        step(8'h80, 1'b0, d2);
        for (int i = 0; i < COL; i++) exp[i*BW +: BW] = m_map((i == COL - 1) ? d2[i*BW +: BW] : d1[i*BW +: BW]);
        total++; if (out !== exp) begin bad++; $display("FAIL rde_out: got %h want %h", out, exp); end
        for (int k = 0; k < 10; k++) step('1, 1'b0, rand_row());
        step('0, 1'b0, '0, 1'b1);
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
        total++; if (out !== '0) begin bad++; $display("FAIL rst_mid_out: got %h want 0", out); end
    endtask

    task automatic test_relu();
        logic [COL*BW-1:0] d, exp;
        step('0, 1'b0, '0, 1'b1);
        for (int i = 0; i < COL; i++) d[i*BW +: BW] = (i % 2 == 0) ? 16'hFFF6 : 16'h0007;
`ifdef PSUM_OFIFO_RELU_EN
        for (int i = 0; i < COL; i++) exp[i*BW +: BW] = (i % 2 == 0) ? 16'h0000 : 16'h0007;
`else
        exp = d;
`endif
        step('1, 1'b0, d);
        total++; if (out !== exp) begin bad++; $display("FAIL relu_out: got %h want %h", out, exp); end
        step('0, 1'b1, '0);
    endtask

    task automatic test_random();
        logic [COL-1:0] w;
        logic r;
        step('0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 700; k++) begin
            w = COL'($urandom);
            r = (k < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            step(w, r, rand_row());
            total++;
            if ({o_valid, o_full, o_ready, o_ovf, out} !==
                {m_valid(), m_full(), ~m_full(), m_ovf, m_out()}) begin
                bad++;
                $display("FAIL random[%0d]: got v%b f%b r%b o%b %h want v%b f%b r%b o%b %h", k,
                         o_valid, o_full, o_ready, o_ovf, out,
                         m_valid(), m_full(), ~m_full(), m_ovf, m_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_skew();
        test_full_ovf();
        test_full_pop_write();
        test_rd_empty();
        test_relu();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
